// File: rtl/id_pipe_scoreboard_if.sv
// Decode-stage handshake bundle: IF/ID input side, ID/EX output side,
// writeback release and flush.
interface id_pipe_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_funct3;
  logic [RW-1:0]   out_rs1_idx;
  logic [RW-1:0]   out_rs2_idx;
  logic [RW-1:0]   out_rd_idx;
  logic            out_rd_wr;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_mem;
  logic            out_wr_mem;
  logic            out_cond_br;
  logic            out_uncond_br;
  logic            out_illegal;

  logic            wb_release;
  logic [RW-1:0]   wb_release_idx;
  logic            flush;

  modport slave (
    input  in_valid, in_inst, in_pc,
    output in_ready,
    output out_valid, out_pc, out_funct3,
    output out_rs1_idx, out_rs2_idx, out_rd_idx,
    output out_rd_wr, out_imm,
    output out_rd_mem, out_wr_mem,
    output out_cond_br, out_uncond_br,
    output out_illegal,
    input  out_ready,
    input  wb_release, wb_release_idx, flush
  );

  modport master (
    output in_valid, in_inst, in_pc,
    input  in_ready,
    input  out_valid, out_pc, out_funct3,
    input  out_rs1_idx, out_rs2_idx, out_rd_idx,
    input  out_rd_wr, out_imm,
    input  out_rd_mem, out_wr_mem,
    input  out_cond_br, out_uncond_br,
    input  out_illegal,
    output out_ready,
    output wb_release, wb_release_idx, flush
  );
endinterface

// File: rtl/id_pipe_scoreboard.sv
// RV32 decode stage with ID/EX register and per-register
// pending-write scoreboard that stalls on RAW hazards.
module id_pipe_scoreboard #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int MAX_INFLIGHT = 3,
  localparam int RW          = $clog2(NREGS),
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic clk,
  input  logic rst,
  id_pipe_scoreboard_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            rd_wr;
    logic [XLEN-1:0] imm;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_br;
    logic            uncond_br;
    logic            illegal;
  } id_ex_t;

  localparam logic [CW:0] ONE = 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  id_ex_t        dec;
  id_ex_t        out_d, out_q;
  logic          out_valid_d, out_valid_q;
  logic [CW-1:0] cnt_d [NREGS];
  logic [CW-1:0] cnt_q [NREGS];

  logic          uses_rs1, uses_rs2;
  logic          hazard, accept, kill, wr_en;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc, is_ebrk;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm;

  assign opc = bus.in_inst[6:0];
  assign f3  = bus.in_inst[14:12];
  assign f7  = bus.in_inst[31:25];

  assign is_r     = opc == 7'b0110011;
  assign is_i     = opc == 7'b0010011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_ebrk  = bus.in_inst == 32'h0010_0073;

  assign i_imm = {{(XLEN-12){bus.in_inst[31]}},
                  bus.in_inst[31:20]};
  assign s_imm = {{(XLEN-12){bus.in_inst[31]}},
                  bus.in_inst[31:25], bus.in_inst[11:7]};
  assign b_imm = {{(XLEN-12){bus.in_inst[31]}},
                  bus.in_inst[7], bus.in_inst[30:25],
                  bus.in_inst[11:8], 1'b0};
  assign j_imm = {{(XLEN-20){bus.in_inst[31]}},
                  bus.in_inst[19:12], bus.in_inst[20],
                  bus.in_inst[30:21], 1'b0};
  assign u_imm = {{(XLEN-32){bus.in_inst[31]}},
                  bus.in_inst[31:12], 12'b0};

  always_comb begin
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.funct3 = f3;
    dec.rs1    = bus.in_inst[15 +: RW];
    dec.rs2    = bus.in_inst[20 +: RW];
    dec.imm    = i_imm;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    unique case (1'b1)
      is_r: begin
        dec.illegal = !(f7 == 7'b0 ||
          (f7 == 7'b0100000 &&
           (f3 == 3'd0 || f3 == 3'd5)));
        dec.rd_wr = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      is_i: begin
        if (f3 == 3'd1)
          dec.illegal = f7 != 7'b0;
        else if (f3 == 3'd5)
          dec.illegal = !(f7 == 7'b0 ||
                          f7 == 7'b0100000);
        dec.rd_wr = 1'b1;
        uses_rs1  = 1'b1;
      end
      is_ld: begin
        dec.illegal = f3 != 3'd2;
        dec.rd_wr   = 1'b1;
        dec.rd_mem  = 1'b1;
        uses_rs1    = 1'b1;
      end
      is_st: begin
        dec.illegal = f3 != 3'd2;
        dec.wr_mem  = 1'b1;
        dec.imm     = s_imm;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      is_br: begin
        dec.illegal = f3 == 3'd2 || f3 == 3'd3;
        dec.cond_br = 1'b1;
        dec.imm     = b_imm;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      is_jal: begin
        dec.rd_wr     = 1'b1;
        dec.uncond_br = 1'b1;
        dec.imm       = j_imm;
      end
      is_jalr: begin
        dec.illegal   = f3 != 3'd0;
        dec.rd_wr     = 1'b1;
        dec.uncond_br = 1'b1;
        uses_rs1      = 1'b1;
      end
      is_lui, is_auipc: begin
        dec.rd_wr = 1'b1;
        dec.imm   = u_imm;
      end
      is_ebrk: begin
        dec.imm = i_imm;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal ops travel as inert bubbles: no flags, no sources.
    if (dec.illegal) begin
      dec.rd_wr     = 1'b0;
      dec.rd_mem    = 1'b0;
      dec.wr_mem    = 1'b0;
      dec.cond_br   = 1'b0;
      dec.uncond_br = 1'b0;
      uses_rs1      = 1'b0;
      uses_rs2      = 1'b0;
    end
    if (dec.rd_wr)
      dec.rd = bus.in_inst[7 +: RW];
  end

  assign wr_en = dec.rd_wr && dec.rd != '0;

  always_comb begin
    hazard = 1'b0;
    if (uses_rs1 && cnt_q[dec.rs1] != '0)
      hazard = 1'b1;
    if (uses_rs2 && cnt_q[dec.rs2] != '0)
      hazard = 1'b1;
    if (wr_en && cnt_q[dec.rd] == CMAX)
      hazard = 1'b1;
  end

  assign bus.in_ready = !rst && !bus.flush && !hazard &&
                        (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign kill   = bus.flush && out_valid_q &&
                  out_q.rd_wr && out_q.rd != '0;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Releases are floored at the current count before the increment.
  always_comb begin
    logic [CW:0] dcnt;
    logic [CW:0] cur;
    logic [CW:0] nxt;
    for (int r = 0; r < NREGS; r++) begin
      dcnt = '0;
      cur  = {1'b0, cnt_q[r]};
      if (bus.wb_release && bus.wb_release_idx == RW'(r))
        dcnt = dcnt + ONE;
      if (kill && out_q.rd == RW'(r))
        dcnt = dcnt + ONE;
      nxt = (dcnt >= cur) ? '0 : cur - dcnt;
      if (accept && wr_en && dec.rd == RW'(r))
        nxt = nxt + ONE;
      cnt_d[r] = (r == 0) ? '0 : nxt[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_funct3    = out_q.funct3;
  assign bus.out_rs1_idx   = out_q.rs1;
  assign bus.out_rs2_idx   = out_q.rs2;
  assign bus.out_rd_idx    = out_q.rd;
  assign bus.out_rd_wr     = out_q.rd_wr;
  assign bus.out_imm       = out_q.imm;
  assign bus.out_rd_mem    = out_q.rd_mem;
  assign bus.out_wr_mem    = out_q.wr_mem;
  assign bus.out_cond_br   = out_q.cond_br;
  assign bus.out_uncond_br = out_q.uncond_br;
  assign bus.out_illegal   = out_q.illegal;

endmodule
